// File: rtl/rop_types.sv
// Shared types and constants for the ROP CSR block: field widths, CSR map,
// reset defaults and the commit FSM state encoding.
package rop_types;

  localparam int unsigned ROP_BLEND_FACTOR_BITS = 5;
  localparam int unsigned TEX_LOGIC_OP_BITS     = 4;

  typedef struct packed {
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_src_rgb;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_dst_rgb;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_src_a;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_dst_a;
    logic [31:0]                      blend_const;
    logic [TEX_LOGIC_OP_BITS-1:0]     logic_op;
  } rop_csrs_t;

  localparam logic [2:0] CSR_BLEND_SRC_RGB = 3'd0;
  localparam logic [2:0] CSR_BLEND_DST_RGB = 3'd1;
  localparam logic [2:0] CSR_BLEND_SRC_A   = 3'd2;
  localparam logic [2:0] CSR_BLEND_DST_A   = 3'd3;
  localparam logic [2:0] CSR_BLEND_CONST   = 3'd4;
  localparam logic [2:0] CSR_LOGIC_OP      = 3'd5;
  localparam logic [2:0] CSR_COMMIT        = 3'd6;
  localparam logic [2:0] CSR_RESERVED      = 3'd7;

  localparam logic [ROP_BLEND_FACTOR_BITS-1:0] BLEND_ZERO    = ROP_BLEND_FACTOR_BITS'(0);
  localparam logic [ROP_BLEND_FACTOR_BITS-1:0] BLEND_ONE     = ROP_BLEND_FACTOR_BITS'(1);
  localparam logic [TEX_LOGIC_OP_BITS-1:0]     LOGIC_OP_COPY = TEX_LOGIC_OP_BITS'(3);

  localparam rop_csrs_t ROP_CSRS_RESET = '{
    blend_src_rgb: BLEND_ONE,
    blend_dst_rgb: BLEND_ZERO,
    blend_src_a:   BLEND_ONE,
    blend_dst_a:   BLEND_ZERO,
    blend_const:   32'h0,
    logic_op:      LOGIC_OP_COPY
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } commit_state_e;

endpackage

// File: rtl/rop_csr_regs.sv
// ROP configuration registers: shadow copy written over the CSR port, active
// copy updated only by a COMMIT once the ROP pipeline has drained.
module rop_csr_regs
  import rop_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_wr_valid,
  input  logic [2:0]  csr_wr_addr,
  input  logic [31:0] csr_wr_data,
  output logic        csr_wr_ready,
  input  logic        csr_rd_valid,
  input  logic [2:0]  csr_rd_addr,
  output logic        csr_rd_rsp_valid,
  output logic [31:0] csr_rd_rsp_data,
  input  logic        rop_idle,
  output rop_csrs_t   rop_csrs,
  output logic        commit_pending,
  output logic        commit_done
);

  commit_state_e state_q;
  logic          ready_q;
  logic          pending_q;
  logic          done_q;
  rop_csrs_t     active_q;
  rop_csrs_t     shadow_q, shadow_d;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          wr_fire;
  logic          commit_req;

  assign wr_fire    = csr_wr_valid & ready_q;
  assign commit_req = wr_fire && (csr_wr_addr == CSR_COMMIT);

  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire) begin
      unique case (csr_wr_addr)
        CSR_BLEND_SRC_RGB: shadow_d.blend_src_rgb = csr_wr_data[ROP_BLEND_FACTOR_BITS-1:0];
        CSR_BLEND_DST_RGB: shadow_d.blend_dst_rgb = csr_wr_data[ROP_BLEND_FACTOR_BITS-1:0];
        CSR_BLEND_SRC_A:   shadow_d.blend_src_a   = csr_wr_data[ROP_BLEND_FACTOR_BITS-1:0];
        CSR_BLEND_DST_A:   shadow_d.blend_dst_a   = csr_wr_data[ROP_BLEND_FACTOR_BITS-1:0];
        CSR_BLEND_CONST:   shadow_d.blend_const   = csr_wr_data;
        CSR_LOGIC_OP:      shadow_d.logic_op      = csr_wr_data[TEX_LOGIC_OP_BITS-1:0];
        default:           shadow_d = shadow_q;
      endcase
    end
  end

  // Read mux works from shadow_q, so a same-cycle write is not yet visible.
  always_comb begin
    rsp_data_d = rsp_data_q;
    if (csr_rd_valid) begin
      unique case (csr_rd_addr)
        CSR_BLEND_SRC_RGB: rsp_data_d = 32'(shadow_q.blend_src_rgb);
        CSR_BLEND_DST_RGB: rsp_data_d = 32'(shadow_q.blend_dst_rgb);
        CSR_BLEND_SRC_A:   rsp_data_d = 32'(shadow_q.blend_src_a);
        CSR_BLEND_DST_A:   rsp_data_d = 32'(shadow_q.blend_dst_a);
        CSR_BLEND_CONST:   rsp_data_d = shadow_q.blend_const;
        CSR_LOGIC_OP:      rsp_data_d = 32'(shadow_q.logic_op);
        CSR_COMMIT:        rsp_data_d = {31'b0, pending_q};
        default:           rsp_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q    <= ROP_CSRS_RESET;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      shadow_q    <= shadow_d;
      rsp_valid_q <= csr_rd_valid;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // rop_idle is only looked at from DRAIN, so the COMMIT cycle itself never
  // shortcuts the drain wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      active_q  <= ROP_CSRS_RESET;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (commit_req) begin
            state_q   <= ST_DRAIN;
            ready_q   <= 1'b0;
            pending_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (rop_idle) begin
            active_q  <= shadow_q;
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_wr_ready     = ready_q;
  assign commit_pending   = pending_q;
  assign commit_done      = done_q;
  assign rop_csrs         = active_q;
  assign csr_rd_rsp_valid = rsp_valid_q;
  assign csr_rd_rsp_data  = rsp_data_q;

endmodule

// File: doc/rop_csr_regs.md
ROP_CSR_REGS -- requirements
Module: rop_csr_regs

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-002 SHALL have reset `reset`, input, 1 bit, asynchronous and active-high.
REQ-003 SHALL have `csr_wr_valid`, input, 1 bit: a CSR write request is present.
REQ-004 SHALL have `csr_wr_addr`, input, 3 bits: CSR index being written.
REQ-005 SHALL have `csr_wr_data`, input, 32 bits: write data.
REQ-006 SHALL have `csr_wr_ready`, output, 1 bit: the write is accepted when valid and ready are both 1.
REQ-007 SHALL have `csr_rd_valid`, input, 1 bit: read request; no backpressure.
REQ-008 SHALL have `csr_rd_addr`, input, 3 bits: CSR index being read.
REQ-009 SHALL have `csr_rd_rsp_valid`, output, 1 bit: read response is valid.
REQ-010 SHALL have `csr_rd_rsp_data`, output, 32 bits: read response data.
REQ-011 SHALL have `rop_idle`, input, 1 bit: the ROP pipeline holds no in-flight fragments.
REQ-012 SHALL have `rop_csrs`, output, type rop_csrs_t: active configuration driven to the ROP datapath.
REQ-013 SHALL have `commit_pending`, output, 1 bit: high while the FSM is in DRAIN.
REQ-014 SHALL have `commit_done`, output, 1 bit: one-cycle pulse when the active copy is updated.

Function
REQ-015 SHALL implement the following CSR map:
- 0 = BLEND_SRC_RGB
- 1 = BLEND_DST_RGB
- 2 = BLEND_SRC_A
- 3 = BLEND_DST_A
- 4 = BLEND_CONST
- 5 = LOGIC_OP
- 6 = COMMIT
- 7 = reserved
REQ-016 SHALL direct every accepted write to addresses 0-5 into a shadow rop_csrs_t; the write stores the low `ROP_BLEND_FACTOR_BITS`, 32, or `TEX_LOGIC_OP_BITS` bits of the data as appropriate; upper bits are ignored.
REQ-017 SHALL treat an accepted write to address 6 as a commit request regardless of data; a write to address 7 is accepted and discarded.
REQ-018 SHALL provide a 2-state FSM:
- IDLE: `csr_wr_ready`=1; an accepted COMMIT write moves the FSM to DRAIN.
- DRAIN: `csr_wr_ready`=0; when `rop_idle`=1, the FSM copies shadow to active at that edge, pulses `commit_done` for the next cycle, and returns to IDLE.
REQ-019 SHALL observe commit latency as follows: for a COMMIT accepted in cycle N with `rop_idle`=1 in cycle N+1, the new `rop_csrs` is visible in cycle N+2; `rop_idle` sampled in cycle N itself SHALL NOT shortcut DRAIN.
REQ-020 SHALL hold `rop_csrs` constant at all times except the commit edge; shadow writes never propagate to `rop_csrs` directly.
REQ-021 SHALL register each read: `csr_rd_valid` in cycle N gives `csr_rd_rsp_valid`=1 in cycle N+1, with data taken as follows:
- addresses 0-5: shadow field, zero-extended;
- address 6: {31'b0, commit_pending};
- address 7: 0.
REQ-022 SHALL resolve a read and write to the same address in the same cycle by returning the pre-write value.
REQ-023 SHALL accept reads in both IDLE and DRAIN; a `csr_wr_valid` that is held during DRAIN is accepted on the first IDLE cycle.
REQ-024 SHALL drive `csr_rd_rsp_valid` and `commit_done` low in every cycle without a corresponding event.

Reset
REQ-025 SHALL, on reset assertion, immediately bring the FSM to IDLE, drop `commit_pending`, `commit_done` and `csr_rd_rsp_valid` to 0, and set `csr_rd_rsp_data` to 0.
REQ-026 SHALL set both the shadow and active copies to src_rgb=src_a=ONE(1), dst_rgb=dst_a=ZERO(0), blend_const=0, logic_op=COPY(3) on reset.
REQ-027 SHALL abandon a commit in DRAIN when reset asserts; the active copy takes its reset defaults, not the shadow values.

Structure
REQ-028 SHALL place the CSR index localparams (0-7), the reset-default constants, and the FSM state enum in package rop_types alongside rop_csrs_t.
REQ-029 SHALL be a single module with no sub-module.

Verification
REQ-030 SHALL cover reset defaults: after reset, `rop_csrs` = {1,0,1,0,32'h0,3}, and a read of address 0 returns 32'h1 one cycle later.
REQ-031 SHALL cover shadow isolation: write addr 4 = 32'hDEADBEEF; `rop_csrs.blend_const` stays 0, and a read of address 4 returns 32'hDEADBEEF.
REQ-032 SHALL cover a commit while idle: `rop_idle`=1 and COMMIT written in cycle N; `commit_done`=1 and blend_const=32'hDEADBEEF in cycle N+2.
REQ-033 SHALL cover a commit blocked by a busy pipeline: `rop_idle`=0 for 5 cycles after COMMIT; `csr_wr_ready`=0, `commit_pending`=1, and a read of address 6 returns 1; after `rop_idle` rises, the commit completes next edge and ready returns.
REQ-034 SHALL cover truncation: write addr 5 = 32'hFFFFFFF7; reading address 5 returns 32'h7 when `TEX_LOGIC_OP_BITS`=4.
REQ-035 SHALL cover reset during DRAIN: assert reset in DRAIN; `commit_pending`=0 immediately, and `rop_csrs` equals the reset defaults.
